weight_seq_ctrl: RTL

- Controller that owns one neuron's weight memory.
- Loads weights from a valid/ready stream into memory write port (non-pretrained builds).
- Sequences read port during inference: one address per valid input sample, with a weight-valid strobe aligned to the memory's registered output.
- Sits between the layer-level config/input path and a single neuron's weight memory and MAC.

---
 rtl/weight_seq_ctrl_pkg.sv | 13 +
 rtl/weight_seq_ctrl_wrap_counter.sv | 31 +++
 rtl/weight_seq_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/weight_seq_ctrl_pkg.sv
// Shared definitions for the neuron weight sequencer: FSM encoding and
// the weight memory read latency that the MAC alignment also depends on.
package weight_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int RD_LAT = 1;

endpackage

// File: rtl/weight_seq_ctrl_wrap_counter.sv
// Address counter that advances on enable and wraps to zero after MAX,
// flagging the wrapping increment combinationally.
module weight_seq_ctrl_wrap_counter
  import weight_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int MAX   = 783
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  assign wrap = en && (cnt == MAX_V);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/weight_seq_ctrl.sv
// Owns one neuron's weight memory: streams weights in while idle and issues
// one read per valid input sample during an inference pass.
module weight_seq_ctrl
  import weight_seq_ctrl_pkg::*;
#(
  parameter int NUM_WEIGHT = 784,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_done,
  input  logic                  start,
  input  logic                  x_valid,
  output logic                  busy,
  output logic                  w_valid,
  output logic                  w_last,
  output logic                  done,
  output logic                  start_err,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_wadd,
  output logic [DATA_WIDTH-1:0] mem_win,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH:0]   mem_radd
);

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] ld_cnt, rd_cnt;
  logic                  ld_wrap, rd_wrap;
  logic                  start_acc, start_rej;
  logic [RD_LAT-1:0]     valid_pipe, last_pipe;

  weight_seq_ctrl_wrap_counter #(
    .WIDTH(ADDR_WIDTH),
    .MAX  (NUM_WEIGHT - 1)
  ) u_ld_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (mem_wen),
    .cnt (ld_cnt),
    .wrap(ld_wrap)
  );

  weight_seq_ctrl_wrap_counter #(
    .WIDTH(ADDR_WIDTH),
    .MAX  (NUM_WEIGHT - 1)
  ) u_rd_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start_acc),
    .en  (mem_ren),
    .cnt (rd_cnt),
    .wrap(rd_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A start with a half-loaded memory would read stale weights, so it is refused.
  always_comb begin
    next_state = state;
    ld_ready   = 1'b0;
    mem_ren    = 1'b0;
    start_acc  = 1'b0;
    start_rej  = 1'b0;
    case (state)
      IDLE: begin
        ld_ready = ~start;
        if (start) begin
          if (ld_cnt == '0) begin
            start_acc  = 1'b1;
            next_state = RUN;
          end else begin
            start_rej = 1'b1;
          end
        end
      end
      RUN: begin
        mem_ren = x_valid;
        if (rd_wrap) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign mem_wen  = ld_valid & ld_ready;
  assign mem_wadd = ld_cnt;
  assign mem_win  = mem_wen ? ld_data : '0;
  assign mem_radd = {1'b0, rd_cnt};
  assign busy     = (state != IDLE);
  assign done     = (state == DRAIN);
  assign w_valid  = valid_pipe[RD_LAT-1];
  assign w_last   = last_pipe[RD_LAT-1];

  // Strobes are delayed by the memory read latency so they line up with wout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_pipe <= '0;
      last_pipe  <= '0;
      ld_done    <= 1'b0;
      start_err  <= 1'b0;
    end else begin
      valid_pipe[0] <= mem_ren;
      last_pipe[0]  <= rd_wrap;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        last_pipe[i]  <= last_pipe[i-1];
      end
      ld_done   <= ld_wrap;
      start_err <= start_rej;
    end
  end

endmodule
